// File: rtl/csd_pkg.sv
// Shared definitions for the CSD coefficient encoder: digit codes,
// FSM state encodings and the default coefficient width.
package csd_pkg;

  localparam int CSD_COEF_W_DEF = 12;

  // Digit codes as consumed by the CSD multiplier
  localparam logic [1:0] CSD_ZERO = 2'b00;
  localparam logic [1:0] CSD_POS  = 2'b01;
  localparam logic [1:0] CSD_NEG  = 2'b10;

  // Encoder FSM states (legacy-compatible plain constants)
  typedef logic [1:0] csd_state_t;
  localparam csd_state_t ST_IDLE = 2'b00;
  localparam csd_state_t ST_ENC  = 2'b01;
  localparam csd_state_t ST_DONE = 2'b10;

endpackage

// File: rtl/csd_encoder_if.sv
// Coefficient-in / CSD-word-out handshake bundle for csd_encoder.
// Optional feature macro: CSD_ENC_NZCNT_EN adds the nz_count signal.
// master = coefficient source / CSD consumer side, slave = encoder.
interface csd_encoder_if #(parameter int COEF_W = csd_pkg::CSD_COEF_W_DEF);
  logic [COEF_W-1:0]   coef_in;
  logic                coef_valid;
  logic                coef_ready;
  logic [2*COEF_W-1:0] csd_out;
  logic                csd_valid;
  logic                csd_ready;
`ifdef CSD_ENC_NZCNT_EN
  logic [3:0]          nz_count;

  modport master (output coef_in, coef_valid, csd_ready,
                  input  coef_ready, csd_out, csd_valid, nz_count);
  modport slave  (input  coef_in, coef_valid, csd_ready,
                  output coef_ready, csd_out, csd_valid, nz_count);
`else
  modport master (output coef_in, coef_valid, csd_ready,
                  input  coef_ready, csd_out, csd_valid);
  modport slave  (input  coef_in, coef_valid, csd_ready,
                  output coef_ready, csd_out, csd_valid);
`endif
endinterface

// File: rtl/csd_digit_cell.sv
// One CSD recoding step: from x(i), x(i+1) and incoming carry c(i) produce
// digit d(i) and carry c(i+1). With is_msb_i the digit is c(i) - x(i).
module csd_digit_cell
  import csd_pkg::*;
(
  input  logic       x_i,
  input  logic       x_nxt_i,
  input  logic       c_i,
  input  logic       is_msb_i,
  output logic [1:0] digit_o,
  output logic       c_o
);

  // Recode one digit; x(i)+c(i)==1 is the only case yielding a nonzero digit
  always_comb begin
    digit_o = CSD_ZERO;
    c_o     = 1'b0;
    if (is_msb_i) begin
      case ({c_i, x_i})
        2'b10:   digit_o = CSD_POS;
        2'b01:   digit_o = CSD_NEG;
        default: digit_o = CSD_ZERO;
      endcase
    end else begin
      c_o = (x_i & x_nxt_i) | (x_i & c_i) | (x_nxt_i & c_i);
      if (x_i ^ c_i) begin
        digit_o = x_nxt_i ? CSD_NEG : CSD_POS;
      end else begin
        digit_o = CSD_ZERO;
      end
    end
  end

endmodule

// File: rtl/csd_encoder.sv
// Sequential canonical-signed-digit encoder, one digit per clock, LSB first.
// Optional feature macro: CSD_ENC_NZCNT_EN adds the nonzero-digit counter.
module csd_encoder
  import csd_pkg::*;
#(
  parameter int COEF_W = CSD_COEF_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  csd_encoder_if.slave  bus
);

  localparam int IDX_W = $clog2(COEF_W);

  csd_state_t          state_q, state_d;
  logic [COEF_W-1:0]   x_q, x_d;        // captured coefficient, shifted right per digit
  logic                carry_q, carry_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [2*COEF_W-1:0] work_q, work_d;  // digits enter at the top, shift down
  logic [2*COEF_W-1:0] csd_q, csd_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic [1:0]          digit_s;
  logic                carry_s;
  logic                is_msb_s;
  logic [2*COEF_W-1:0] work_shift_s;
`ifdef CSD_ENC_NZCNT_EN
  logic [3:0]          nz_cnt_q, nz_cnt_d;
  logic [3:0]          nz_out_q, nz_out_d;
  logic [3:0]          nz_inc_s;
`endif

  assign is_msb_s     = (idx_q == IDX_W'(COEF_W - 1));
  assign work_shift_s = {digit_s, work_q[2*COEF_W-1:2]};
`ifdef CSD_ENC_NZCNT_EN
  assign nz_inc_s     = nz_cnt_q + {3'b000, (digit_s != CSD_ZERO)};
`endif

  csd_digit_cell u_cell (
    .x_i      (x_q[0]),
    .x_nxt_i  (x_q[1]),
    .c_i      (carry_q),
    .is_msb_i (is_msb_s),
    .digit_o  (digit_s),
    .c_o      (carry_s)
  );

  // Next-state logic: capture in IDLE, one digit per cycle in ENC, hold in DONE
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    work_d  = work_q;
    csd_d   = csd_q;
`ifdef CSD_ENC_NZCNT_EN
    nz_cnt_d = nz_cnt_q;
    nz_out_d = nz_out_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.coef_valid) begin
          x_d     = bus.coef_in;
          carry_d = 1'b0;
          idx_d   = '0;
          work_d  = '0;
`ifdef CSD_ENC_NZCNT_EN
          nz_cnt_d = 4'd0;
`endif
          state_d = ST_ENC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENC: begin
        work_d  = work_shift_s;
        x_d     = {1'b0, x_q[COEF_W-1:1]};
        carry_d = carry_s;
`ifdef CSD_ENC_NZCNT_EN
        nz_cnt_d = nz_inc_s;
`endif
        if (is_msb_s) begin
          csd_d   = work_shift_s;
`ifdef CSD_ENC_NZCNT_EN
          nz_out_d = nz_inc_s;
`endif
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_ENC;
        end
      end
      ST_DONE: begin
        if (bus.csd_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any conversion in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      work_q  <= '0;
      csd_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
`ifdef CSD_ENC_NZCNT_EN
      nz_cnt_q <= 4'd0;
      nz_out_q <= 4'd0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
      csd_q   <= csd_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
`ifdef CSD_ENC_NZCNT_EN
      nz_cnt_q <= nz_cnt_d;
      nz_out_q <= nz_out_d;
`endif
    end
  end

  assign bus.coef_ready = ready_q;
  assign bus.csd_valid  = valid_q;
  assign bus.csd_out    = csd_q;
`ifdef CSD_ENC_NZCNT_EN
  assign bus.nz_count   = nz_out_q;
`endif

endmodule

// File: tb/tb_csd_encoder.sv
// Directed and sweep bench for csd_encoder (default 12-bit coefficient).
module tb_csd_encoder;
  import csd_pkg::*;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  csd_encoder_if #(.COEF_W(W)) bif ();

  csd_encoder #(.COEF_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  logic [11:0] vec_in  [6] = '{12'h7FF, 12'hFFF, 12'h800, 12'h555, 12'h003, 12'h000};
  logic [23:0] vec_out [6] = '{24'h400002, 24'h000002, 24'h800000, 24'h111111, 24'h000012, 24'h000000};
  logic [3:0]  vec_nz  [6] = '{4'd2, 4'd1, 4'd1, 4'd6, 4'd2, 4'd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Offer one coefficient from IDLE and wait (bounded) for csd_valid.
  task automatic run_coef(input logic [11:0] val, output logic [23:0] word, output int lat);
    @(negedge clk);
    bif.coef_in    = val;
    bif.coef_valid = 1'b1;
    @(negedge clk);
    bif.coef_valid = 1'b0;
    bif.coef_in    = ~val;
    lat = 0;
    while (!bif.csd_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    word = bif.csd_out;
  endtask

  // Accept the output word and check the encoder returns to IDLE.
  task automatic take_out(input string tag);
    bif.csd_ready = 1'b1;
    @(negedge clk);
    bif.csd_ready = 1'b0;
    chk(tag, {31'd0, bif.coef_ready}, 32'd1);
  endtask

  function automatic int csd_sum(input logic [23:0] w);
    int s = 0;
    for (int i = 0; i < W; i++) begin
      case (w[2*i +: 2])
        2'b01:   s = s + (1 << i);
        2'b10:   s = s - (1 << i);
        default: s = s;
      endcase
    end
    return s;
  endfunction

  // Counts illegal codes plus adjacent nonzero pairs among digits 0..W-2.
  function automatic int csd_bad(input logic [23:0] w);
    int b = 0;
    for (int i = 0; i < W; i++) begin
      if (w[2*i +: 2] == 2'b11) b++;
    end
    for (int i = 0; i < W - 2; i++) begin
      if (w[2*i +: 2] != 2'b00 && w[2*i+2 +: 2] != 2'b00) b++;
    end
    return b;
  endfunction

  function automatic int csd_nz(input logic [23:0] w);
    int n = 0;
    for (int i = 0; i < W; i++) begin
      if (w[2*i +: 2] != 2'b00) n++;
    end
    return n;
  endfunction

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] word;
    int          lat;
    logic signed [11:0] sval;
    int          expv;

    bif.coef_in    = 12'h000;
    bif.coef_valid = 1'b0;
    bif.csd_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_coef_ready", {31'd0, bif.coef_ready}, 32'd1);
    chk("rst_csd_valid",  {31'd0, bif.csd_valid},  32'd0);
    chk("rst_csd_out",    {8'd0, bif.csd_out},     32'd0);
`ifdef CSD_ENC_NZCNT_EN
    chk("rst_nz_count",   {28'd0, bif.nz_count},   32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    for (int k = 0; k < 6; k++) begin
      run_coef(vec_in[k], word, lat);
      chk($sformatf("lat_%h", vec_in[k]), 32'(lat), 32'd12);
      chk($sformatf("csd_%h", vec_in[k]), {8'd0, word}, {8'd0, vec_out[k]});
`ifdef CSD_ENC_NZCNT_EN
      chk($sformatf("nz_%h", vec_in[k]), {28'd0, bif.nz_count}, {28'd0, vec_nz[k]});
`endif
      take_out($sformatf("idle_after_%h", vec_in[k]));
      chk($sformatf("hold_%h", vec_in[k]), {8'd0, bif.csd_out}, {8'd0, vec_out[k]});
    end

    // Backpressure: new offers ignored while DONE is held
    run_coef(12'h555, word, lat);
    chk("bp_first", {8'd0, word}, 32'h00111111);
    for (int c = 0; c < 5; c++) begin
      bif.coef_in    = 12'h7FF;
      bif.coef_valid = ~bif.coef_valid;
      @(negedge clk);
      chk("bp_valid",  {31'd0, bif.csd_valid},  32'd1);
      chk("bp_ready",  {31'd0, bif.coef_ready}, 32'd0);
      chk("bp_stable", {8'd0, bif.csd_out},     32'h00111111);
    end
    bif.coef_valid = 1'b0;
    take_out("bp_release");
    chk("bp_valid_low", {31'd0, bif.csd_valid}, 32'd0);
    run_coef(12'h003, word, lat);
    chk("bp_next", {8'd0, word}, 32'h00000012);
    take_out("bp_next_idle");

    // Asynchronous reset in the middle of ENC
    @(negedge clk);
    bif.coef_in    = 12'h7FF;
    bif.coef_valid = 1'b1;
    @(negedge clk);
    bif.coef_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, bif.coef_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, bif.csd_valid},  32'd0);
    chk("mid_rst_out",   {8'd0, bif.csd_out},     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_coef(12'h003, word, lat);
    chk("post_rst_lat", 32'(lat), 32'd12);
    chk("post_rst_csd", {8'd0, word}, 32'h00000012);
    take_out("post_rst_idle");

    // Exhaustive sweep of every 12-bit coefficient
    for (int v = 0; v < 4096; v++) begin
      sval = 12'(v);
      expv = sval;
      run_coef(12'(v), word, lat);
      chk("sweep_lat", 32'(lat), 32'd12);
      chk("sweep_sum", 32'(csd_sum(word)), 32'(expv));
      chk("sweep_legal", 32'(csd_bad(word)), 32'd0);
`ifdef CSD_ENC_NZCNT_EN
      chk("sweep_nz", {28'd0, bif.nz_count}, 32'(csd_nz(word)));
`endif
      take_out("sweep_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/csd_encoder.md
# csd_encoder

Sequential canonical-signed-digit encoder. It converts a two's-complement filter/SDM coefficient into the 2-bits-per-digit CSD word consumed by the CSD multiplier (CSD_mult_SDM). It sits in the coefficient-load path of the DAC digital front end, between coefficient storage and the multiplier's `CSD_in`. It emits one digit per clock, LSB first, behind valid/ready handshakes on both sides.

## Interface
- `COEF_W`, default 12: coefficient width in bits. The CSD word is 2*`COEF_W` bits.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `coef_in` in `COEF_W`: signed coefficient. Sampled only on an input handshake.
- `coef_valid` in 1: coefficient offered.
- `coef_ready` out 1: encoder idle and able to accept. Reset value 1.
- `csd_out` out 2*`COEF_W`: CSD word. Digit i occupies bits [2i+1:2i]. Reset value 0.
- `csd_valid` out 1: `csd_out` holds a completed word. Reset value 0.
- `csd_ready` in 1: downstream accepts `csd_out`.
- `nz_count` out 4: count of nonzero digits. Present only with `CSD_ENC_NZCNT_EN`. Reset value 0.

## Operation
- Digit codes: 2'b00 = 0, 2'b01 = +1, 2'b10 = −1. The code 2'b11 is never emitted.
- Recoding (x = captured coefficient, c0 = 0):
  - For i = 0..`COEF_W`−2: c(i+1) = majority(x(i), x(i+1), c(i)); d(i) = x(i) + c(i) − 2·c(i+1).
  - MSB digit: d(`COEF_W`−1) = c(`COEF_W`−1) − x(`COEF_W`−1).
  - Result: sum d(i)·2^i equals the signed input exactly.
  - Digits 0..`COEF_W`−2 are non-adjacent (never two consecutive nonzero digits).
- FSM states:
  - IDLE: `coef_ready`=1. On `coef_valid`&&`coef_ready`, capture `coef_in`, clear carry, digit index and working register, and go to ENC.
  - ENC: one digit per clock into the working shift register; index counts 0..`COEF_W`−1. After the MSB digit, load `csd_out` (and `nz_count`) from the working result and go to DONE.
  - DONE: `csd_valid`=1. On `csd_ready`, go to IDLE. Otherwise hold.
- `csd_out`/`nz_count` change only on ENC→DONE. They retain the last word until the next completion.
- `coef_valid` outside IDLE is ignored. `coef_in` changes after capture have no effect.
- `csd_ready` asserted outside DONE is ignored.
- Asynchronous reset at any point, including mid-ENC, aborts the conversion. All outputs return to reset values; the in-flight coefficient is discarded.

## Timing
- Input handshake at edge E0. Digits are produced on edges E1..E`COEF_W`.
- `csd_valid` rises after edge E`COEF_W` (12 cycles for the default).
- If `csd_ready` is already high: output handshake at edge E`COEF_W`+1, `coef_ready` high after it, next acceptance earliest at E`COEF_W`+2. Minimum period is 14 cycles for the default.
- `coef_ready` = (state == IDLE). `csd_valid` = (state == DONE). Both are registered state decodes with no combinational path from inputs.
- Backpressure holds DONE indefinitely with outputs stable.

## Configuration
- `CSD_ENC_NZCNT_EN` defined:
  - Adds the `nz_count` port.
  - A counter increments on each nonzero digit during ENC, is cleared on capture, and is registered with `csd_out`.
  - Maximum value is ceil(`COEF_W`/2) (6 for the default).
- Not defined: port and counter absent. All other behaviour is identical.

## Structure
- Shared package `csd_pkg` holds:
  - Digit code constants `CSD_ZERO`, `CSD_POS`, `CSD_NEG`.
  - FSM state type/encodings IDLE/ENC/DONE.
  - Default coefficient width constant.
- One combinational sub-module, `csd_digit_cell`:
  - Inputs: x(i), x(i+1), c(i), and an `is_msb` flag.
  - Outputs: 2-bit digit code and c(i+1).
  - Instantiated once and reused serially.

## Test plan
- 12'h7FF (2047) → `csd_out`=24'h400002 (d11=+1, d0=−1), `nz_count`=2. `csd_valid` rises exactly 12 cycles after accept.
- 12'hFFF (−1) → 24'h000002, `nz_count`=1. 12'h800 (−2048) → 24'h800000, `nz_count`=1.
- 12'h555 → 24'h111111, `nz_count`=6. 12'h003 → 24'h000012, `nz_count`=2.
- Hold `csd_ready`=0 for 5 cycles after `csd_valid`, toggling `coef_valid` with a new value → `csd_out` stable, `coef_ready`=0, new value not captured. Release → IDLE next cycle.
- Assert `rst_n`=0 at cycle 6 of ENC → `coef_ready`=1, `csd_valid`=0, `csd_out`=0 immediately. A fresh coefficient after release encodes correctly.
- Exhaustive sweep of all 4096 inputs → decoded digit sum equals input, no 2'b11 codes, digits 0..10 non-adjacent. Feeding each word to CSD_mult_SDM with `Data_in`=1 yields `Data_out` equal to the sign-extended coefficient.
